lfsr_word_arbiter: RTL and testbench

//  Shares one Galois LFSR between NREQ requesters. Each grant collects a WORD-bit

---
 rtl/lfsr_word_arbiter_if.sv | 25 ++
 rtl/lfsr_word_arbiter.sv | 126 ++++++++++++
 tb/tb_lfsr_word_arbiter.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_word_arbiter_if.sv
// Request/grant and word-delivery bundle between the LFSR word arbiter and its requesters.
interface lfsr_word_arbiter_if #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned WORD = 4
);
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] req;
    logic            reseed;
    logic [NREQ-1:0] gnt;
    logic            busy;
    logic            word_valid;
    logic [WORD-1:0] word;
    logic [IDW-1:0]  word_id;

    modport master (
        output req, reseed,
        input  gnt, busy, word_valid, word, word_id
    );

    modport slave (
        input  req, reseed,
        output gnt, busy, word_valid, word, word_id
    );
endinterface

// File: rtl/lfsr_word_arbiter.sv
// One Galois LFSR shared round-robin between NREQ requesters; each grant
// collects a WORD-bit word, one LFSR bit per cycle, delivered with a 1-cycle strobe.
module lfsr_word_arbiter #(
    parameter int unsigned      WIDTH = 5,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'('h12),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'('h9),
    parameter int unsigned      NREQ  = 2,
    parameter int unsigned      WORD  = 4
) (
    input  logic              clk,
    input  logic              rst_,
    lfsr_word_arbiter_if.slave bus
);
    localparam int unsigned   IDW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned   CW       = $clog2(WORD + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WORD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WORD-1:0]  word_q, word_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   last_q, last_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;

    logic             win_found;
    logic [IDW-1:0]   win_idx;
    logic [IDW-1:0]   cand;

    // Round-robin search starting just above the previous winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = IDW'((32'(last_q) + i) % NREQ);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!bus.reseed && win_found) state_d = SHIFT;
            SHIFT:   if (cnt_q == LAST_BIT)        state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reseed in IDLE takes priority over a grant; SHIFT is the only state that steps the LFSR.
    always_comb begin
        s_d    = s_q;
        cnt_d  = cnt_q;
        word_d = word_q;
        id_d   = id_q;
        last_d = last_q;
        gnt_d  = gnt_q;
        case (state_q)
            IDLE: begin
                if (bus.reseed) begin
                    s_d = SEED;
                end else if (win_found) begin
                    gnt_d  = NREQ'(1) << win_idx;
                    id_d   = win_idx;
                    last_d = win_idx;
                    cnt_d  = '0;
                    word_d = '0;
                end
            end
            SHIFT: begin
                word_d = word_q | (WORD'(s_q[0]) << cnt_q);
                s_d    = (s_q >> 1) ^ (s_q[0] ? TAPS : '0);
                cnt_d  = cnt_q + CW'(1);
            end
            DONE:    gnt_d = '0;
            default: gnt_d = '0;
        endcase
        busy_d  = (state_d != IDLE);
        valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            s_q     <= SEED;
            cnt_q   <= '0;
            word_q  <= '0;
            id_q    <= '0;
            last_q  <= IDW'(NREQ - 1);
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            id_q    <= id_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.busy       = busy_q;
    assign bus.word_valid = valid_q;
    assign bus.word       = word_q;
    assign bus.word_id    = id_q;
endmodule

// File: tb/tb_lfsr_word_arbiter.sv
// Bench for lfsr_word_arbiter: reference table, directed corner sequences and
// randomized traffic against a transaction-level model.
module tb_lfsr_word_arbiter;
    localparam int unsigned      WIDTH = 5;
    localparam logic [WIDTH-1:0] TAPS  = 5'h12;
    localparam logic [WIDTH-1:0] SEED  = 5'h09;
    localparam int unsigned      NREQ  = 2;
    localparam int unsigned      WORD  = 4;

    logic clk;
    logic rst_;
    int   n_cmp;
    int   n_err;

    lfsr_word_arbiter_if #(.NREQ(NREQ), .WORD(WORD)) bus ();

    lfsr_word_arbiter #(
        .WIDTH(WIDTH), .TAPS(TAPS), .SEED(SEED), .NREQ(NREQ), .WORD(WORD)
    ) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] req;
        logic [1:0] gnt;
        logic       busy;
        logic       valid;
        logic [3:0] word;
        logic       id;
    } vec_t;

    vec_t tbl[18];

    // Transaction-level model state
    logic [WIDTH-1:0] m_s;
    int               m_last;
    int               m_rem;
    int               m_id;
    logic [WORD-1:0]  m_word;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_       = 1'b0;
        bus.req    = '0;
        bus.reseed = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt",   32'(bus.gnt), 32'h0);
        chk("rst_busy",  32'(bus.busy), 32'h0);
        chk("rst_valid", 32'(bus.word_valid), 32'h0);
        chk("rst_word",  32'(bus.word), 32'h0);
        chk("rst_id",    32'(bus.word_id), 32'h0);
        rst_   = 1'b1;
        m_s    = SEED;
        m_last = NREQ - 1;
        m_rem  = 0;
        m_id   = 0;
        m_word = '0;
    endtask

    task automatic wait_valid(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (bus.word_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_valid: no word_valid within %0d cycles, expected one", budget);
        end
    endtask

    // Produce the whole word a grant will collect, straight from the LFSR rule.
    task automatic model_word(output logic [WORD-1:0] w);
        logic b;
        w = '0;
        for (int i = 0; i < int'(WORD); i++) begin
            b    = m_s[0];
            w[i] = b;
            m_s  = (m_s >> 1) ^ (b ? TAPS : '0);
        end
    endtask

    // Advance the model by one clock edge given the inputs seen at that edge.
    task automatic model_edge(input logic [NREQ-1:0] r, input logic rs);
        int idx;
        if (m_rem == 0) begin
            if (rs) begin
                m_s = SEED;
            end else if (r != '0) begin
                for (int k = 1; k <= int'(NREQ); k++) begin
                    idx = (m_last + k) % int'(NREQ);
                    if (r[idx]) break;
                end
                m_id   = idx;
                m_last = idx;
                model_word(m_word);
                m_rem  = WORD + 1;
            end
        end else begin
            m_rem--;
        end
    endtask

    initial begin
        logic            ok;
        int              cyc;
        int              low;
        logic [NREQ-1:0] r;
        logic            rs;

        n_cmp = 0;
        n_err = 0;

        // req=11 held: grants 0,1,0 with words D, D, 8
        tbl[0]  = '{2'b11, 2'b01, 1'b1, 1'b0, 4'h0, 1'b0};
        tbl[1]  = '{2'b11, 2'b01, 1'b1, 1'b0, 4'h0, 1'b0};
        tbl[2]  = '{2'b11, 2'b01, 1'b1, 1'b0, 4'h0, 1'b0};
        tbl[3]  = '{2'b11, 2'b01, 1'b1, 1'b0, 4'h0, 1'b0};
        tbl[4]  = '{2'b11, 2'b01, 1'b1, 1'b1, 4'hD, 1'b0};
        tbl[5]  = '{2'b11, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0};
        tbl[6]  = '{2'b11, 2'b10, 1'b1, 1'b0, 4'h0, 1'b0};
        tbl[7]  = '{2'b11, 2'b10, 1'b1, 1'b0, 4'h0, 1'b0};
        tbl[8]  = '{2'b11, 2'b10, 1'b1, 1'b0, 4'h0, 1'b0};
        tbl[9]  = '{2'b11, 2'b10, 1'b1, 1'b0, 4'h0, 1'b0};
        tbl[10] = '{2'b11, 2'b10, 1'b1, 1'b1, 4'hD, 1'b1};
        tbl[11] = '{2'b11, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0};
        tbl[12] = '{2'b11, 2'b01, 1'b1, 1'b0, 4'h0, 1'b0};
        tbl[13] = '{2'b11, 2'b01, 1'b1, 1'b0, 4'h0, 1'b0};
        tbl[14] = '{2'b11, 2'b01, 1'b1, 1'b0, 4'h0, 1'b0};
        tbl[15] = '{2'b11, 2'b01, 1'b1, 1'b0, 4'h0, 1'b0};
        tbl[16] = '{2'b11, 2'b01, 1'b1, 1'b1, 4'h8, 1'b0};
        tbl[17] = '{2'b11, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0};

        do_reset();
        for (int k = 0; k < 18; k++) begin
            bus.req = tbl[k].req;
            step();
            chk($sformatf("tbl%0d_gnt", k),   32'(bus.gnt),        32'(tbl[k].gnt));
            chk($sformatf("tbl%0d_busy", k),  32'(bus.busy),       32'(tbl[k].busy));
            chk($sformatf("tbl%0d_valid", k), 32'(bus.word_valid), 32'(tbl[k].valid));
            if (tbl[k].valid) begin
                chk($sformatf("tbl%0d_word", k), 32'(bus.word),    32'(tbl[k].word));
                chk($sformatf("tbl%0d_id", k),   32'(bus.word_id), 32'(tbl[k].id));
            end
            if (k == 10) chk("lfsr_after_2nd", 32'(dut.s_q), 32'h18);
        end

        // Back-to-back single requester: word every WORD+2 cycles, one idle gnt gap
        do_reset();
        bus.req = 2'b01;
        wait_valid(20, ok);
        for (int n = 0; n < 2; n++) begin
            cyc = 0;
            low = 0;
            for (int i = 0; i < 20; i++) begin
                step();
                cyc++;
                if (bus.gnt == '0) low++;
                if (bus.word_valid === 1'b1) break;
            end
            chk("period", 32'(cyc), 32'(WORD + 2));
            chk("gnt_gap", 32'(low), 32'h1);
        end

        // Reseed in IDLE blocks the grant that cycle and restarts the sequence
        do_reset();
        bus.req = 2'b01;
        wait_valid(20, ok);
        chk("rs_word1", 32'(bus.word), 32'hD);
        step();
        bus.reseed = 1'b1;
        step();
        bus.reseed = 1'b0;
        chk("rs_nogrant", 32'(bus.gnt), 32'h0);
        chk("rs_seed", 32'(dut.s_q), 32'(SEED));
        step();
        chk("rs_grant", 32'(bus.gnt), 32'h1);
        wait_valid(20, ok);
        chk("rs_word2", 32'(bus.word), 32'hD);
        wait_valid(20, ok);
        chk("rs_word3", 32'(bus.word), 32'hD);

        // Reseed during SHIFT is ignored
        do_reset();
        bus.req = 2'b01;
        step();
        step();
        bus.reseed = 1'b1;
        step();
        bus.reseed = 1'b0;
        wait_valid(20, ok);
        chk("rsb_word1", 32'(bus.word), 32'hD);
        for (int i = 0; i < 3; i++) step();
        bus.reseed = 1'b1;
        step();
        bus.reseed = 1'b0;
        wait_valid(20, ok);
        chk("rsb_word2", 32'(bus.word), 32'hD);
        wait_valid(20, ok);
        chk("rsb_word3", 32'(bus.word), 32'h8);

        // Asynchronous reset mid-SHIFT
        do_reset();
        bus.req = 2'b01;
        step();
        step();
        step();
        #3;
        rst_ = 1'b0;
        #1;
        chk("ar_gnt", 32'(bus.gnt), 32'h0);
        chk("ar_valid", 32'(bus.word_valid), 32'h0);
        chk("ar_busy", 32'(bus.busy), 32'h0);
        step();
        rst_ = 1'b1;
        wait_valid(20, ok);
        chk("ar_word", 32'(bus.word), 32'hD);
        chk("ar_id", 32'(bus.word_id), 32'h0);

        // Requester drops mid-transaction: word still delivered, then requester 1 served
        do_reset();
        bus.req = 2'b01;
        step();
        chk("drop_gnt0", 32'(bus.gnt), 32'h1);
        bus.req = 2'b10;
        wait_valid(20, ok);
        chk("drop_id0", 32'(bus.word_id), 32'h0);
        chk("drop_word0", 32'(bus.word), 32'hD);
        step();
        step();
        chk("drop_gnt1", 32'(bus.gnt), 32'h2);
        wait_valid(20, ok);
        chk("drop_id1", 32'(bus.word_id), 32'h1);
        chk("drop_word1", 32'(bus.word), 32'hD);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            r  = NREQ'($urandom_range(0, 3));
            rs = ($urandom_range(0, 7) == 0);
            bus.req    = r;
            bus.reseed = rs;
            step();
            model_edge(r, rs);
            chk("rnd_gnt",   32'(bus.gnt),        (m_rem > 0) ? (32'h1 << m_id) : 32'h0);
            chk("rnd_busy",  32'(bus.busy),       32'(m_rem > 0));
            chk("rnd_valid", 32'(bus.word_valid), 32'(m_rem == 1));
            if (m_rem == 1) begin
                chk("rnd_word", 32'(bus.word),    32'(m_word));
                chk("rnd_id",   32'(bus.word_id), 32'(m_id));
            end
        end
        bus.req    = '0;
        bus.reseed = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
